// File: rtl/step_button_ctrl_pkg.sv
// Shared types for the step-button front end: FSM states, key codes and
// the key decode helper used by the top level.
package step_button_ctrl_pkg;

  // FSM states of the step/auto-repeat controller
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  // Decoded key seen by the FSM
  typedef enum logic [1:0] {
    KEY_NONE = 2'd0,
    KEY_UP   = 2'd1,
    KEY_DN   = 2'd2
  } key_e;

  // Exactly one pressed button selects a key; none or both never step.
  function automatic key_e decode_key(input logic up, input logic dn);
    key_e key;
    if (up && !dn) begin
      key = KEY_UP;
    end else if (dn && !up) begin
      key = KEY_DN;
    end else begin
      key = KEY_NONE;
    end
    return key;
  endfunction

endpackage

// File: rtl/step_button_ctrl_btn_debounce.sv
// Two-flop synchroniser followed by a stability-counter debouncer for one
// raw push-button. The debounced level flips only after the synchronised
// input has disagreed with it for DEBOUNCE_CYCLES consecutive samples.
module btn_debounce
  import step_button_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic [CNT_W-1:0] cnt_r;
  logic             level_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;

  // Synchroniser chain: raw goes straight into two flops with no logic between
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // Stability counter: clear on agreement, count on disagreement, flip at the last count
  always_comb begin
    level_nxt_s = level_r;
    cnt_nxt_s   = cnt_r;
    if (sync2_r == level_r) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (cnt_r == CNT_LAST) begin
      level_nxt_s = sync2_r;
      cnt_nxt_s   = CNT_ZERO;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // Debounce state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_r <= 1'b0;
      cnt_r   <= CNT_ZERO;
    end else begin
      level_r <= level_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign level = level_r;

endmodule

// File: rtl/step_button_ctrl.sv
// Up/down step-button controller: two debounced buttons are decoded into a
// key, and an IDLE/DELAY/REPEAT FSM turns that key into one-cycle enable
// pulses (first press, then auto-repeat) plus a held direction level that
// drives an up/down counter directly.
module step_button_ctrl
  import step_button_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 8,
  parameter int TMR_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_up,
  input  logic btn_down,
  output logic enable,
  output logic direction,
  output logic held
);

  localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);
  localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_ZERO    = TMR_W'(0);

  logic             up_level_s;
  logic             dn_level_s;
  key_e             key_s;

  state_e           state_r;
  state_e           state_nxt_s;
  key_e             key_r;
  key_e             key_nxt_s;
  logic [TMR_W-1:0] timer_r;
  logic [TMR_W-1:0] timer_nxt_s;
  logic             enable_r;
  logic             enable_nxt_s;
  logic             direction_r;
  logic             direction_nxt_s;
  logic             held_r;
  logic             held_nxt_s;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_up (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_up),
    .level(up_level_s)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_down (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_down),
    .level(dn_level_s)
  );

  assign key_s = decode_key(up_level_s, dn_level_s);

  // Next-state, timer and registered-output logic; any key change drops back to IDLE
  always_comb begin
    state_nxt_s     = state_r;
    key_nxt_s       = key_r;
    timer_nxt_s     = timer_r;
    enable_nxt_s    = 1'b0;
    direction_nxt_s = direction_r;
    case (state_r)
      ST_IDLE: begin
        if (key_s != KEY_NONE) begin
          enable_nxt_s    = 1'b1;
          direction_nxt_s = (key_s == KEY_UP);
          key_nxt_s       = key_s;
          timer_nxt_s     = TMR_ZERO;
          state_nxt_s     = ST_DELAY;
        end else begin
          key_nxt_s   = KEY_NONE;
          timer_nxt_s = TMR_ZERO;
        end
      end
      ST_DELAY: begin
        if (key_s != key_r) begin
          key_nxt_s   = KEY_NONE;
          timer_nxt_s = TMR_ZERO;
          state_nxt_s = ST_IDLE;
        end else if (timer_r == DELAY_LAST) begin
          enable_nxt_s = 1'b1;
          timer_nxt_s  = TMR_ZERO;
          state_nxt_s  = ST_REPEAT;
        end else begin
          timer_nxt_s = timer_r + TMR_ONE;
        end
      end
      ST_REPEAT: begin
        if (key_s != key_r) begin
          key_nxt_s   = KEY_NONE;
          timer_nxt_s = TMR_ZERO;
          state_nxt_s = ST_IDLE;
        end else if (timer_r == PERIOD_LAST) begin
          enable_nxt_s = 1'b1;
          timer_nxt_s  = TMR_ZERO;
        end else begin
          timer_nxt_s = timer_r + TMR_ONE;
        end
      end
      default: begin
        key_nxt_s   = KEY_NONE;
        timer_nxt_s = TMR_ZERO;
        state_nxt_s = ST_IDLE;
      end
    endcase
    held_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // FSM state, timer and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      key_r       <= KEY_NONE;
      timer_r     <= TMR_ZERO;
      enable_r    <= 1'b0;
      direction_r <= 1'b1;
      held_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      key_r       <= key_nxt_s;
      timer_r     <= timer_nxt_s;
      enable_r    <= enable_nxt_s;
      direction_r <= direction_nxt_s;
      held_r      <= held_nxt_s;
    end
  end

  assign enable    = enable_r;
  assign direction = direction_r;
  assign held      = held_r;

endmodule

// File: tb/tb_step_button_ctrl.sv
// Directed bench for step_button_ctrl with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3. Inputs change 1 time unit after a
// rising edge ("after edge k"); outputs are sampled at the same point, so
// the value seen after edge k is what the DUT registered on edge k.
// A press applied after edge 0 shows its first pulse after edge 7.
module tb_step_button_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic enable;
  logic direction;
  logic held;

  int total_cnt = 0;
  int pass_cnt = 0;

  logic [63:0] en_m;
  logic [63:0] dir_m;
  logic [63:0] held_m;

  step_button_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .TMR_W          (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .enable   (enable),
    .direction(direction),
    .held     (held)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int k, input logic obs, input logic exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s @%0d: observed %b expected %b", tag, k, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run n edges from "edge 0" (now). Button/reset changes are applied after
  // the given edge index (-1 = never). en_m/held_m give the expected value
  // after each edge; dir_m gives the direction expected at each pulse, and
  // direction must hold that value between pulses.
  task automatic run(input string tag, input int n,
                     input int up_on, input int up_off,
                     input int dn_on, input int dn_off,
                     input int rst_at, input logic dir_start,
                     input logic [63:0] em, input logic [63:0] dm,
                     input logic [63:0] hm);
    logic exp_dir;
    exp_dir = dir_start;
    for (int k = 0; k <= n; k++) begin
      if (k > 0) begin
        step();
        if (k == rst_at) exp_dir = 1'b1;
        if (em[k]) exp_dir = dm[k];
        check({tag, ".enable"}, k, enable, em[k]);
        check({tag, ".direction"}, k, direction, exp_dir);
        check({tag, ".held"}, k, held, hm[k]);
      end
      if (k == up_on)      btn_up = 1'b1;
      if (k == up_off)     btn_up = 1'b0;
      if (k == dn_on)      btn_down = 1'b1;
      if (k == dn_off)     btn_down = 1'b0;
      if (k == rst_at - 1) rst_n = 1'b0;
      if (k == rst_at)     rst_n = 1'b1;
    end
  endtask

  initial begin
    // 1: reset with random buttons, then idle with buttons released
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      btn_up   = 1'($urandom_range(1, 0));
      btn_down = 1'($urandom_range(1, 0));
      step();
      check("reset.enable", i, enable, 1'b0);
      check("reset.direction", i, direction, 1'b1);
      check("reset.held", i, held, 1'b0);
    end
    btn_up   = 1'b0;
    btn_down = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("idle.enable", i, enable, 1'b0);
      check("idle.direction", i, direction, 1'b1);
      check("idle.held", i, held, 1'b0);
    end

    // 2: tap released before the repeat delay: one pulse at 7, held 7..14
    en_m = 64'd0; dir_m = 64'd0; held_m = 64'd0;
    en_m[7] = 1'b1; dir_m[7] = 1'b1;
    for (int i = 7; i <= 14; i++) held_m[i] = 1'b1;
    run("tap", 20, 0, 8, -1, -1, -1, 1'b1, en_m, dir_m, held_m);

    // 3: bouncing down button never settles long enough to register
    for (int k = 0; k < 30; k++) begin
      btn_down = ((k / 2) % 2 == 0) ? 1'b1 : 1'b0;
      step();
      check("bounce.enable", k, enable, 1'b0);
      check("bounce.held", k, held, 1'b0);
      check("bounce.direction", k, direction, 1'b1);
    end
    btn_down = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("bounce_tail.enable", k, enable, 1'b0);
      check("bounce_tail.held", k, held, 1'b0);
    end

    // 4: hold down: pulses 7, 17, then every 3 cycles until release is seen
    en_m = 64'd0; dir_m = 64'd0; held_m = 64'd0;
    en_m[7] = 1'b1; en_m[17] = 1'b1;
    for (int i = 20; i <= 44; i += 3) en_m[i] = 1'b1;
    for (int i = 7; i <= 46; i++) held_m[i] = 1'b1;
    run("hold", 50, -1, -1, 0, 40, -1, 1'b1, en_m, dir_m, held_m);

    // 5: up held, down added (stops), up released (down stepped), down released
    en_m = 64'd0; dir_m = 64'd0; held_m = 64'd0;
    en_m[7] = 1'b1; dir_m[7] = 1'b1;
    en_m[27] = 1'b1; dir_m[27] = 1'b0;
    for (int i = 7; i <= 14; i++) held_m[i] = 1'b1;
    for (int i = 27; i <= 35; i++) held_m[i] = 1'b1;
    run("both", 40, 0, 20, 8, 29, -1, 1'b0, en_m, dir_m, held_m);

    // 6: up held into REPEAT, one-cycle reset at edge 22, re-stepped at 29
    en_m = 64'd0; dir_m = 64'd0; held_m = 64'd0;
    en_m[7] = 1'b1; en_m[17] = 1'b1; en_m[20] = 1'b1;
    en_m[29] = 1'b1; en_m[39] = 1'b1; en_m[42] = 1'b1; en_m[45] = 1'b1;
    dir_m = ~64'd0;
    for (int i = 7; i <= 21; i++) held_m[i] = 1'b1;
    for (int i = 29; i <= 46; i++) held_m[i] = 1'b1;
    run("rst_mid", 50, 0, 40, -1, -1, 22, 1'b0, en_m, dir_m, held_m);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
